pq_cmd_frontend: RTL

//  Command front-end sitting directly upstream of the BRAM-based priority-queue tree.
//  - Accepts ENQ / DEQ / REPLACE commands over a valid/ready handshake and buffers them in a small FIFO.
//  - Issues one-cycle o_pq_wrt / o_pq_read strobes to the tree and waits for the tree's compare-and-swap to settle.
//  - Tracks occupancy, rejects illegal commands, and returns one response per command.

---
 rtl/pq_pkg.sv | 25 ++
 rtl/pq_cmd_fifo.sv | 55 +++++
 rtl/pq_cmd_frontend.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command front-end.
package pq_pkg;

   // Widest key carried through the command FIFO; DATA_WIDTH of the
   // front-end must not exceed this.
   localparam int PQ_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      PQ_ENQ     = 2'd0,
      PQ_DEQ     = 2'd1,
      PQ_REPLACE = 2'd2,
      PQ_RSVD    = 2'd3
   } pq_op_t;

   typedef struct packed {
      pq_op_t                   op;
      logic [PQ_DATA_WIDTH-1:0] data;
   } pq_cmd_t;

   // Occupancy counter width able to hold 0..queue_size inclusive.
   function automatic int cnt_w(input int queue_size);
      return $clog2(queue_size + 1);
   endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Small synchronous command FIFO; the head entry is read straight out of
// the storage flops so the consumer sees it without an extra cycle.
module pq_cmd_fifo
   import pq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    CLK,
   input  logic    RSTn,
   input  logic    push_i,
   input  pq_cmd_t wdata_i,
   input  logic    pop_i,
   output pq_cmd_t head_o,
   output logic    empty_o,
   output logic    full_o
);

   localparam int AW = $clog2(DEPTH);

   pq_cmd_t     mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   // Storage write
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   // Pointer update; the extra MSB distinguishes full from empty
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/pq_cmd_frontend.sv
// Command front-end for the BRAM priority-queue tree: buffers commands,
// checks legality against occupancy, strobes the tree and returns one
// response per command.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for a command at the FIFO head
//  ST_ISSUE  | tree strobe(s) high for this single cycle, count updated
//  ST_SETTLE | waiting SETTLE_CYCLES for the tree compare-and-swap
//  ST_RESP   | response presented until accepted
module pq_cmd_frontend
   import pq_pkg::*;
#(
   parameter int QUEUE_SIZE     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int CMD_FIFO_DEPTH = 4,
   parameter int SETTLE_CYCLES  = 4
) (
   input  logic                              CLK,
   input  logic                              RSTn,
   input  logic                              i_cmd_valid,
   input  logic [1:0]                        i_cmd_op,
   input  logic [DATA_WIDTH-1:0]             i_cmd_data,
   output logic                              o_cmd_ready,
   output logic                              o_rsp_valid,
   output logic [DATA_WIDTH-1:0]             o_rsp_data,
   output logic                              o_rsp_err,
   input  logic                              i_rsp_ready,
   output logic                              o_pq_wrt,
   output logic                              o_pq_read,
   output logic [DATA_WIDTH-1:0]             o_pq_data,
   input  logic [DATA_WIDTH-1:0]             i_pq_data,
   output logic [cnt_w(QUEUE_SIZE)-1:0]      o_count,
   output logic                              o_empty,
   output logic                              o_full
);

   localparam int CW = cnt_w(QUEUE_SIZE);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_RESP} state_t;

   state_t                state_q;
   pq_op_t                cmd_op_q;
   logic [SW-1:0]         settle_q;
   logic [CW-1:0]         count_q;
   logic                  wrt_q;
   logic                  read_q;
   logic [DATA_WIDTH-1:0] pq_data_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;

   pq_cmd_t               fifo_wdata;
   pq_cmd_t               fifo_head;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  head_legal;

   assign fifo_wdata.op   = pq_op_t'(i_cmd_op);
   assign fifo_wdata.data = PQ_DATA_WIDTH'(i_cmd_data);

   // The head is consumed from IDLE, or from RESP in the cycle the response
   // is accepted so back-to-back commands lose no cycle.
   assign fifo_pop    = !fifo_empty &&
                        ((state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready));
   assign o_cmd_ready = !fifo_full || fifo_pop;
   assign fifo_push   = i_cmd_valid && o_cmd_ready;

   pq_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_fifo (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Legality of the head command against current occupancy
   always_comb begin
      head_legal = 1'b0;
      case (fifo_head.op)
         PQ_ENQ:     head_legal = (count_q != CW'(QUEUE_SIZE));
         PQ_DEQ:     head_legal = (count_q != '0);
         PQ_REPLACE: head_legal = (count_q != '0);
         default:    head_legal = 1'b0;
      endcase
   end

   // Sequencer: strobes, settle timer, occupancy and response register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_IDLE;
         cmd_op_q    <= PQ_ENQ;
         settle_q    <= '0;
         count_q     <= '0;
         wrt_q       <= 1'b0;
         read_q      <= 1'b0;
         pq_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         wrt_q     <= 1'b0;
         read_q    <= 1'b0;
         pq_data_q <= '0;
         if (fifo_pop) begin
            cmd_op_q   <= fifo_head.op;
            rsp_data_q <= '0;
            if (head_legal) begin
               state_q     <= ST_ISSUE;
               wrt_q       <= (fifo_head.op == PQ_ENQ) || (fifo_head.op == PQ_REPLACE);
               read_q      <= (fifo_head.op == PQ_DEQ) || (fifo_head.op == PQ_REPLACE);
               pq_data_q   <= fifo_head.data[DATA_WIDTH-1:0];
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
            end else begin
               state_q     <= ST_RESP;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
            end
         end else begin
            case (state_q)
               ST_ISSUE: begin
                  case (cmd_op_q)
                     PQ_ENQ:  count_q <= count_q + CW'(1);
                     PQ_DEQ:  count_q <= count_q - CW'(1);
                     default: count_q <= count_q;
                  endcase
                  if (cmd_op_q != PQ_ENQ) rsp_data_q <= i_pq_data;
                  settle_q <= SW'(SETTLE_CYCLES - 1);
                  state_q  <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (settle_q == '0) begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     settle_q <= settle_q - SW'(1);
                  end
               end
               ST_RESP: begin
                  if (i_rsp_ready) begin
                     state_q     <= ST_IDLE;
                     rsp_valid_q <= 1'b0;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= '0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_pq_wrt    = wrt_q;
   assign o_pq_read   = read_q;
   assign o_pq_data   = pq_data_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_count     = count_q;
   assign o_empty     = (count_q == '0);
   assign o_full      = (count_q == CW'(QUEUE_SIZE));

endmodule
